// File: rtl/hazard_pkg.sv
// Shared opcode/funct constants, stall cause codes and instruction-class
// decode helpers for the hazard controller.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_MEM    = 3'd1,
    CAUSE_LOAD   = 3'd2,
    CAUSE_BRANCH = 3'd3,
    CAUSE_MD     = 3'd4
  } cause_e;

  function automatic logic usesRs(input logic [5:0] op);
    usesRs = !(op == OP_J || op == OP_JAL || op == OP_LUI);
  endfunction

  function automatic logic usesRt(input logic [5:0] op);
    usesRt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

  function automatic logic isBranch(input logic [5:0] op);
    isBranch = (op == OP_REGIMM) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

  // HI/LO readers/writers and mult/div ops all contend with an in-flight mult/div.
  function automatic logic isMdConsumer(input logic [5:0] op, input logic [5:0] fn);
    isMdConsumer = (op == OP_RTYPE) &&
                   (fn == FN_MFHI || fn == FN_MTHI || fn == FN_MFLO || fn == FN_MTLO ||
                    fn == FN_MULT || fn == FN_MULTU || fn == FN_DIV || fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: stage fields in, PC/pipeline-register
// control pins and stall statistics out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [5:0]        Opcode_IFID;
  logic [5:0]        Funct_IFID;
  logic [REG_AW-1:0] RsAddr_IFID;
  logic [REG_AW-1:0] RtAddr_IFID;
  logic              BranchTaken_ID;
  logic              MemRd_IDEX;
  logic              RegWr_IDEX;
  logic [REG_AW-1:0] WrAddr_IDEX;
  logic              MdOp_IDEX;
  logic              MemRd_EXMEM;
  logic [REG_AW-1:0] WrAddr_EXMEM;
  logic              DMemBusy;

  logic              PCWre;
  logic              IFID_Stall;
  logic              IFID_Flush;
  logic              IDEX_Stall;
  logic              IDEX_Flush;
  logic              EXMEM_Stall;
  logic              MEMWB_Flush;
  logic              MdBusy;
  logic [CNT_W-1:0]  StallCycles;
  logic [2:0]        LastCause;

  modport master (
    output Opcode_IFID, Funct_IFID, RsAddr_IFID, RtAddr_IFID, BranchTaken_ID,
           MemRd_IDEX, RegWr_IDEX, WrAddr_IDEX, MdOp_IDEX,
           MemRd_EXMEM, WrAddr_EXMEM, DMemBusy,
    input  PCWre, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush,
           EXMEM_Stall, MEMWB_Flush, MdBusy, StallCycles, LastCause
  );

  modport slave (
    input  Opcode_IFID, Funct_IFID, RsAddr_IFID, RtAddr_IFID, BranchTaken_ID,
           MemRd_IDEX, RegWr_IDEX, WrAddr_IDEX, MdOp_IDEX,
           MemRd_EXMEM, WrAddr_EXMEM, DMemBusy,
    output PCWre, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush,
           EXMEM_Stall, MEMWB_Flush, MdBusy, StallCycles, LastCause
  );
endinterface

// File: rtl/md_busy_cnt.sv
// Mult/div occupancy counter: loads MD_LAT-1 when an op is accepted into EX,
// then counts down to zero.
module md_busy_cnt #(
  parameter int MD_LAT = 4
) (
  input  logic CLK,
  input  logic Reset,
  input  logic load,
  output logic busy
);
  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LAT - 1);

  logic [CW-1:0] mdCnt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      mdCnt <= '0;
    end else if (load) begin
      mdCnt <= LOAD_VAL;
    end else if (mdCnt != '0) begin
      mdCnt <= mdCnt - CW'(1);
    end
  end

  assign busy = (mdCnt != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline with branches
// resolved in ID; also freezes on data-memory wait and mult/div occupancy.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input logic         CLK,
  input logic         Reset,
  hazard_ctrl_if.slave bus
);
  import hazard_pkg::*;

  // A source only conflicts if the instruction reads it and it is not $0.
  function automatic logic srcMatch(input logic [5:0]        op,
                                    input logic [REG_AW-1:0] rs,
                                    input logic [REG_AW-1:0] rt,
                                    input logic [REG_AW-1:0] addr);
    srcMatch = (usesRs(op) && (rs != '0) && (rs == addr)) ||
               (usesRt(op) && (rt != '0) && (rt == addr));
  endfunction

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    satInc = (&v) ? v : v + CNT_W'(1);
  endfunction

  logic   mdBusyRaw;
  logic   mdLoad;
  logic   matchEx;
  logic   matchMem;
  logic   loadHaz;
  logic   branchHaz;
  logic   mdHaz;
  cause_e cause;

  logic pcWre;
  logic ifidStall;
  logic ifidFlush;
  logic idexStall;
  logic idexFlush;
  logic exmemStall;
  logic memwbFlush;

  logic [CNT_W-1:0] stallCnt;
  cause_e           lastCause;

  assign matchEx  = srcMatch(bus.Opcode_IFID, bus.RsAddr_IFID, bus.RtAddr_IFID, bus.WrAddr_IDEX);
  assign matchMem = srcMatch(bus.Opcode_IFID, bus.RsAddr_IFID, bus.RtAddr_IFID, bus.WrAddr_EXMEM);

  assign loadHaz   = bus.MemRd_IDEX && matchEx;
  // ALU results can be forwarded to ID from EX/MEM, but a load in MEM cannot.
  assign branchHaz = isBranch(bus.Opcode_IFID) &&
                     ((bus.RegWr_IDEX && !bus.MemRd_IDEX && matchEx) ||
                      (bus.MemRd_EXMEM && matchMem));
  assign mdHaz     = isMdConsumer(bus.Opcode_IFID, bus.Funct_IFID) &&
                     (bus.MdOp_IDEX || mdBusyRaw);

  always_comb begin
    pcWre      = 1'b1;
    ifidStall  = 1'b0;
    ifidFlush  = 1'b0;
    idexStall  = 1'b0;
    idexFlush  = 1'b0;
    exmemStall = 1'b0;
    memwbFlush = 1'b0;
    cause      = CAUSE_NONE;
    if (Reset) begin
      cause = CAUSE_NONE;
    end else if (bus.DMemBusy) begin
      cause      = CAUSE_MEM;
      pcWre      = 1'b0;
      ifidStall  = 1'b1;
      idexStall  = 1'b1;
      exmemStall = 1'b1;
      memwbFlush = 1'b1;
    end else if (loadHaz || branchHaz || mdHaz) begin
      cause     = loadHaz ? CAUSE_LOAD : (branchHaz ? CAUSE_BRANCH : CAUSE_MD);
      pcWre     = 1'b0;
      ifidStall = 1'b1;
      idexFlush = 1'b1;
    end else begin
      ifidFlush = bus.BranchTaken_ID;
    end
  end

  // A mult/div held in EX by a memory freeze has not started yet.
  assign mdLoad = bus.MdOp_IDEX && !exmemStall;

  md_busy_cnt #(.MD_LAT(MD_LAT)) uMdBusyCnt (
    .CLK   (CLK),
    .Reset (Reset),
    .load  (mdLoad),
    .busy  (mdBusyRaw)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stallCnt  <= '0;
      lastCause <= CAUSE_NONE;
    end else if (!pcWre) begin
      stallCnt  <= satInc(stallCnt);
      lastCause <= cause;
    end
  end

  assign bus.PCWre       = pcWre;
  assign bus.IFID_Stall  = ifidStall;
  assign bus.IFID_Flush  = ifidFlush;
  assign bus.IDEX_Stall  = idexStall;
  assign bus.IDEX_Flush  = idexFlush;
  assign bus.EXMEM_Stall = exmemStall;
  assign bus.MEMWB_Flush = memwbFlush;
  assign bus.MdBusy      = mdBusyRaw && !Reset;
  assign bus.StallCycles = stallCnt;
  assign bus.LastCause   = lastCause;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus
// randomized traffic against a cycle-indexed behavioural model.
module tb_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 3;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus();

  hazard_ctrl #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model state: mult/div occupancy is tracked as "cycle index of last accepted op".
  int cycM      = 0;
  int mdLoadCyc = 0;
  bit mdValid   = 1'b0;
  int stallM    = 0;
  int lastM     = 0;
  bit armed     = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit srcHit(input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] a);
    bit rsU;
    bit rtU;
    rsU = !(op inside {6'h02, 6'h03, 6'h0F});
    rtU = op inside {6'h00, 6'h04, 6'h05, 6'h2B};
    return (rsU && rs != 5'd0 && rs == a) || (rtU && rt != 5'd0 && rt == a);
  endfunction

  function automatic bit mdBusyM();
    return mdValid && (cycM - mdLoadCyc) >= 1 && (cycM - mdLoadCyc) <= MD_LAT - 1;
  endfunction

  function automatic int expCause();
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic [4:0] rt;
    op = bus.Opcode_IFID;
    fn = bus.Funct_IFID;
    rs = bus.RsAddr_IFID;
    rt = bus.RtAddr_IFID;
    if (Reset) return 0;
    if (bus.DMemBusy) return 1;
    if (bus.MemRd_IDEX && srcHit(op, rs, rt, bus.WrAddr_IDEX)) return 2;
    if ((op inside {6'h01, 6'h04, 6'h05, 6'h06, 6'h07}) &&
        ((bus.RegWr_IDEX && !bus.MemRd_IDEX && srcHit(op, rs, rt, bus.WrAddr_IDEX)) ||
         (bus.MemRd_EXMEM && srcHit(op, rs, rt, bus.WrAddr_EXMEM)))) return 3;
    if (op == 6'h00 && (fn inside {[6'h10:6'h13], [6'h18:6'h1B]}) &&
        (bus.MdOp_IDEX || mdBusyM())) return 4;
    return 0;
  endfunction

  always @(posedge CLK) begin
    int c;
    c = expCause();
    if (Reset) begin
      mdValid = 1'b0;
      stallM  = 0;
      lastM   = 0;
      armed   = 1'b1;
    end else begin
      if (c != 0) begin
        if (stallM < (1 << CNT_W) - 1) stallM++;
        lastM = c;
      end
      if (bus.MdOp_IDEX && c != 1) begin
        mdValid   = 1'b1;
        mdLoadCyc = cycM;
      end
    end
    cycM++;
  end

  always @(negedge CLK) begin
    int c;
    if (armed) begin
      c = expCause();
      chk("PCWre",       int'(bus.PCWre),       int'(c == 0));
      chk("IFID_Stall",  int'(bus.IFID_Stall),  int'(c != 0));
      chk("IFID_Flush",  int'(bus.IFID_Flush),  int'(c == 0 && !Reset && bus.BranchTaken_ID));
      chk("IDEX_Stall",  int'(bus.IDEX_Stall),  int'(c == 1));
      chk("IDEX_Flush",  int'(bus.IDEX_Flush),  int'(c >= 2));
      chk("EXMEM_Stall", int'(bus.EXMEM_Stall), int'(c == 1));
      chk("MEMWB_Flush", int'(bus.MEMWB_Flush), int'(c == 1));
      chk("MdBusy",      int'(bus.MdBusy),      int'(mdBusyM() && !Reset));
      chk("StallCycles", int'(bus.StallCycles), stallM);
      chk("LastCause",   int'(bus.LastCause),   lastM);
    end
  end

  task automatic setId(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt);
    bus.Opcode_IFID = op;
    bus.Funct_IFID  = fn;
    bus.RsAddr_IFID = rs;
    bus.RtAddr_IFID = rt;
  endtask

  task automatic setEx(input logic memRd, input logic regWr, input logic [4:0] wr,
                       input logic mdOp);
    bus.MemRd_IDEX  = memRd;
    bus.RegWr_IDEX  = regWr;
    bus.WrAddr_IDEX = wr;
    bus.MdOp_IDEX   = mdOp;
  endtask

  task automatic setMem(input logic memRd, input logic [4:0] wr);
    bus.MemRd_EXMEM  = memRd;
    bus.WrAddr_EXMEM = wr;
  endtask

  task automatic idle();
    setId(6'h00, 6'h00, 5'd0, 5'd0);
    setEx(1'b0, 1'b0, 5'd0, 1'b0);
    setMem(1'b0, 5'd0);
    bus.BranchTaken_ID = 1'b0;
    bus.DMemBusy       = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    Reset = 1'b1;
    idle();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nStall;
    int nBusy;
    logic [5:0] ops [12];
    logic [5:0] fns [8];
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h0F, 6'h2B, 6'h23, 6'h08};
    fns = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h1B, 6'h20, 6'h14};

    Reset = 1'b1;
    idle();
    tick();
    tick();
    Reset = 1'b0;
    @(negedge CLK);
    chk("rst_pcwre", int'(bus.PCWre), 1);
    chk("rst_stall", int'(bus.StallCycles), 0);
    chk("rst_cause", int'(bus.LastCause), 0);
    chk("rst_mdbusy", int'(bus.MdBusy), 0);
    tick();

    // lw $8 in EX, add $9,$8,$3 in ID
    setEx(1'b1, 1'b1, 5'd8, 1'b0);
    setId(6'h00, 6'h20, 5'd8, 5'd3);
    @(negedge CLK);
    chk("lu_pcwre", int'(bus.PCWre), 0);
    chk("lu_idexflush", int'(bus.IDEX_Flush), 1);
    tick();
    setEx(1'b0, 1'b0, 5'd0, 1'b0);
    setMem(1'b1, 5'd8);
    @(negedge CLK);
    chk("lu_release", int'(bus.PCWre), 1);
    chk("lu_cause", int'(bus.LastCause), 2);
    chk("lu_count", int'(bus.StallCycles), 1);
    tick();

    // lw $8, beq $8,$9: LOAD then BRANCH
    doReset();
    setEx(1'b1, 1'b1, 5'd8, 1'b0);
    setId(6'h04, 6'h00, 5'd8, 5'd9);
    @(negedge CLK);
    chk("bl_first", int'(bus.PCWre), 0);
    tick();
    setEx(1'b0, 1'b0, 5'd0, 1'b0);
    setMem(1'b1, 5'd8);
    @(negedge CLK);
    chk("bl_second", int'(bus.PCWre), 0);
    chk("bl_cause1", int'(bus.LastCause), 2);
    tick();
    setMem(1'b0, 5'd0);
    @(negedge CLK);
    chk("bl_release", int'(bus.PCWre), 1);
    chk("bl_cause2", int'(bus.LastCause), 3);
    chk("bl_count", int'(bus.StallCycles), 2);
    tick();

    // $0 never creates a hazard
    setEx(1'b0, 1'b1, 5'd0, 1'b0);
    setId(6'h04, 6'h00, 5'd0, 5'd5);
    @(negedge CLK);
    chk("zero_branch", int'(bus.PCWre), 1);
    tick();
    setEx(1'b1, 1'b1, 5'd0, 1'b0);
    setId(6'h00, 6'h20, 5'd0, 5'd3);
    @(negedge CLK);
    chk("zero_load", int'(bus.PCWre), 1);
    tick();

    // mult then mfhi directly behind
    doReset();
    setEx(1'b0, 1'b0, 5'd0, 1'b1);
    setId(6'h00, 6'h10, 5'd0, 5'd0);
    nStall = 0;
    nBusy  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (!bus.PCWre) nStall++;
      if (bus.MdBusy) nBusy++;
      tick();
      setEx(1'b0, 1'b0, 5'd0, 1'b0);
    end
    chk("md_direct_stalls", nStall, MD_LAT);
    chk("md_direct_busy", nBusy, MD_LAT - 1);

    // mult, one unrelated instruction, then mfhi
    doReset();
    setEx(1'b0, 1'b0, 5'd0, 1'b1);
    setId(6'h00, 6'h00, 5'd0, 5'd0);
    tick();
    setEx(1'b0, 1'b0, 5'd0, 1'b0);
    setId(6'h00, 6'h10, 5'd0, 5'd0);
    nStall = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (!bus.PCWre) nStall++;
      tick();
    end
    chk("md_k2_stalls", nStall, 3);

    // DMemBusy for 3 cycles over a pending load-use, with a taken branch
    doReset();
    setEx(1'b1, 1'b1, 5'd8, 1'b0);
    setId(6'h00, 6'h20, 5'd8, 5'd3);
    bus.DMemBusy       = 1'b1;
    bus.BranchTaken_ID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("fz_pcwre", int'(bus.PCWre), 0);
      chk("fz_exmem", int'(bus.EXMEM_Stall), 1);
      chk("fz_memwb", int'(bus.MEMWB_Flush), 1);
      chk("fz_ifidflush", int'(bus.IFID_Flush), 0);
      tick();
    end
    bus.DMemBusy = 1'b0;
    @(negedge CLK);
    chk("fz_load_flush", int'(bus.IDEX_Flush), 1);
    chk("fz_load_idexstall", int'(bus.IDEX_Stall), 0);
    chk("fz_load_ifidflush", int'(bus.IFID_Flush), 0);
    tick();
    setEx(1'b0, 1'b0, 5'd0, 1'b0);
    setMem(1'b1, 5'd8);
    @(negedge CLK);
    chk("fz_count", int'(bus.StallCycles), 4);
    chk("fz_cause", int'(bus.LastCause), 2);
    chk("fz_branchflush", int'(bus.IFID_Flush), 1);
    tick();
    idle();

    // Reset while MdCnt=2
    doReset();
    setEx(1'b0, 1'b0, 5'd0, 1'b1);
    setId(6'h00, 6'h12, 5'd0, 5'd0);
    tick();
    setEx(1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    @(negedge CLK);
    chk("rmd_busy_before", int'(bus.MdBusy), 1);
    Reset = 1'b1;
    #1;
    chk("rmd_forced_busy", int'(bus.MdBusy), 0);
    chk("rmd_forced_pcwre", int'(bus.PCWre), 1);
    tick();
    Reset = 1'b0;
    @(negedge CLK);
    chk("rmd_busy_after", int'(bus.MdBusy), 0);
    chk("rmd_count_after", int'(bus.StallCycles), 0);
    chk("rmd_cause_after", int'(bus.LastCause), 0);
    tick();
    idle();

    // Saturation: 9 stall cycles on a 3-bit counter
    doReset();
    bus.DMemBusy = 1'b1;
    repeat (9) tick();
    bus.DMemBusy = 1'b0;
    @(negedge CLK);
    chk("sat_count", int'(bus.StallCycles), 7);
    chk("sat_cause", int'(bus.LastCause), 1);
    tick();

    // Randomized traffic; the per-cycle compare process checks everything
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 63) == 0);
      setId(ops[$urandom_range(0, 11)], fns[$urandom_range(0, 7)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      setEx(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0));
      setMem(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)));
      bus.DMemBusy       = ($urandom_range(0, 5) == 0);
      bus.BranchTaken_ID = 1'($urandom_range(0, 1));
      tick();
    end
    Reset = 1'b0;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
